// File: rtl/switch_fabric_arbiter_if.sv
// Request/grant and crossbar-steering signals between the fabric inputs and the
// per-output arbiter.
interface switch_fabric_arbiter_if #(
    parameter int unsigned INPUT_QTY  = 4,
    parameter int unsigned OUTPUT_QTY = 4,
    parameter int unsigned DEST_W     = 2,
    parameter int unsigned SEL_W      = 2
);
    logic                         hold;
    logic [INPUT_QTY-1:0]         req_valid;
    logic [INPUT_QTY*DEST_W-1:0]  req_dest;
    logic [INPUT_QTY-1:0]         grant;
    logic [OUTPUT_QTY-1:0]        out_valid;
    logic [OUTPUT_QTY*SEL_W-1:0]  out_sel;
    logic                         bad_dest;

    modport master (
        output hold, req_valid, req_dest,
        input  grant, out_valid, out_sel, bad_dest
    );

    modport slave (
        input  hold, req_valid, req_dest,
        output grant, out_valid, out_sel, bad_dest
    );
endinterface

// File: rtl/switch_fabric_arbiter.sv
// Per-output round-robin arbiter steering the fabric crossbar.
// Optional per-output conflict counters are enabled by defining SWITCH_ARB_STATS_EN.
module switch_fabric_arbiter #(
    parameter int unsigned INPUT_QTY  = 4,
    parameter int unsigned OUTPUT_QTY = 4,
    parameter int unsigned DEST_W     = 2,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef SWITCH_ARB_STATS_EN
    input  logic                     stats_clr,
    output logic [OUTPUT_QTY*16-1:0] conflict_cnt,
`endif
    switch_fabric_arbiter_if.slave   bus
);
    logic [INPUT_QTY-1:0]        cand [OUTPUT_QTY];
    logic [OUTPUT_QTY-1:0]       has_win;
    logic [SEL_W-1:0]            win_idx [OUTPUT_QTY];
    logic [SEL_W-1:0]            rr_ptr_q [OUTPUT_QTY];
    logic [SEL_W-1:0]            rr_ptr_d [OUTPUT_QTY];
    logic [INPUT_QTY-1:0]        win_vec;
    logic                        bad_any;
    logic [OUTPUT_QTY-1:0]       out_valid_q;
    logic [OUTPUT_QTY*SEL_W-1:0] out_sel_q;
    logic                        bad_q;

    // Out-of-range destinations match no output, so they can never win.
    always_comb begin : candidates
        bad_any = 1'b0;
        for (int o = 0; o < OUTPUT_QTY; o++) cand[o] = '0;
        for (int i = 0; i < INPUT_QTY; i++) begin
            if (bus.req_valid[i]) begin
                if (32'(bus.req_dest[i*DEST_W +: DEST_W]) >= OUTPUT_QTY) begin
                    bad_any = 1'b1;
                end else begin
                    for (int o = 0; o < OUTPUT_QTY; o++) begin
                        if (bus.req_dest[i*DEST_W +: DEST_W] == DEST_W'(o)) cand[o][i] = 1'b1;
                    end
                end
            end
        end
    end

    // Rotate candidates so bit 0 is the pointer position, then take the first set bit.
    always_comb begin : winners
        logic [INPUT_QTY-1:0] rot;
        int unsigned          pos;
        win_vec = '0;
        for (int o = 0; o < OUTPUT_QTY; o++) begin
            has_win[o] = 1'b0;
            win_idx[o] = '0;
            pos        = 0;
            rot        = INPUT_QTY'({cand[o], cand[o]} >> rr_ptr_q[o]);
            for (int k = 0; k < INPUT_QTY; k++) begin
                if (!has_win[o] && rot[k]) begin
                    has_win[o] = 1'b1;
                    pos        = 32'(rr_ptr_q[o]) + unsigned'(k);
                    if (pos >= INPUT_QTY) pos = pos - INPUT_QTY;
                    win_idx[o] = SEL_W'(pos);
                end
            end
            rr_ptr_d[o] = (32'(win_idx[o]) == INPUT_QTY - 1) ? '0 : win_idx[o] + SEL_W'(1);
            for (int i = 0; i < INPUT_QTY; i++) begin
                if (has_win[o] && win_idx[o] == SEL_W'(i)) win_vec[i] = 1'b1;
            end
        end
    end

    assign bus.grant = (rst && !bus.hold) ? win_vec : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < OUTPUT_QTY; o++) rr_ptr_q[o] <= '0;
            out_valid_q <= '0;
            out_sel_q   <= '0;
            bad_q       <= 1'b0;
        end else begin
            bad_q <= bad_any;
            for (int o = 0; o < OUTPUT_QTY; o++) begin
                if (has_win[o] && !bus.hold) begin
                    out_valid_q[o]                <= 1'b1;
                    out_sel_q[o*SEL_W +: SEL_W]   <= win_idx[o];
                    rr_ptr_q[o]                   <= rr_ptr_d[o];
                end else begin
                    out_valid_q[o] <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.bad_dest  = bad_q;

`ifdef SWITCH_ARB_STATS_EN
    logic [OUTPUT_QTY-1:0] multi_cand;
    logic [15:0]           conflict_q [OUTPUT_QTY];

    always_comb begin : conflicts
        int unsigned n_cand;
        for (int o = 0; o < OUTPUT_QTY; o++) begin
            n_cand = 0;
            for (int i = 0; i < INPUT_QTY; i++) begin
                if (cand[o][i]) n_cand = n_cand + 1;
            end
            multi_cand[o] = (n_cand >= 2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < OUTPUT_QTY; o++) conflict_q[o] <= '0;
        end else begin
            for (int o = 0; o < OUTPUT_QTY; o++) begin
                if (stats_clr) begin
                    conflict_q[o] <= '0;
                end else if (!bus.hold && multi_cand[o] && conflict_q[o] != 16'hFFFF) begin
                    conflict_q[o] <= conflict_q[o] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        conflict_cnt = '0;
        for (int o = 0; o < OUTPUT_QTY; o++) conflict_cnt[o*16 +: 16] = conflict_q[o];
    end
`endif
endmodule
